// File: rtl/rx_serial_7e1_if.sv
// rx_serial_7e1_if -- signal bundle for the 7E1 serial receiver.
//   dado_serial    : asynchronous serial line, idle high
//   dado_recebido  : last received 7-bit word
//   pronto         : one-cycle frame-complete pulse
//   erro_paridade  : even-parity mismatch on the last frame
//   erro_parada    : framing error (stop bit low) on the last frame
//   db_estado      : current receiver state code (debug)
// The slave modport is the receiver; the master modport is whoever drives
// the line and consumes the results.
interface rx_serial_7e1_if;
  logic       dado_serial;
  logic [6:0] dado_recebido;
  logic       pronto;
  logic       erro_paridade;
  logic       erro_parada;
  logic [3:0] db_estado;

  modport master (
    output dado_serial,
    input  dado_recebido, pronto, erro_paridade, erro_parada, db_estado
  );

  modport slave (
    input  dado_serial,
    output dado_recebido, pronto, erro_paridade, erro_parada, db_estado
  );
endinterface

// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1 -- 7 data bits, even parity, 1 stop bit serial receiver.
//   clock : system clock, rising-edge
//   reset : asynchronous, active-low
//   bus   : rx_serial_7e1_if.slave (line in, word/flags/pronto/debug out)
//
// state    | code | meaning
// ---------+------+---------------------------------------------------
// INICIAL  |  0   | idle, waiting for a low level on the line
// START    |  1   | timing to the start-bit midpoint, glitch rejection
// DADOS    |  2   | sampling the 7 data bits, LSB first
// PARIDADE |  3   | sampling the parity bit
// PARADA   |  4   | sampling the stop bit, results registered here
// FINAL    |  5   | results visible, pronto high for this one cycle
// ESPERA   |  6   | framing error seen, waiting for the line to go high
module rx_serial_7e1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic            clock,
  input logic            reset,
  rx_serial_7e1_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    START    = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    FINAL    = 4'd5,
    ESPERA   = 4'd6
  } state_t;

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // The timer is cleared on the edge that enters START, so reaching
  // HALF_TC means the edge CLKS_PER_BIT/2 cycles after that one.
  localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_TC  = TW'(CLKS_PER_BIT - 1);

  state_t          state, state_nxt;
  logic            sync_q1, sync;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_cnt;
  logic [6:0]      shift;
  logic            par_bit;
  logic [6:0]      data_q;
  logic            perr_q;
  logic            serr_q;
  logic            pronto_q;

  logic            half_tc, bit_tc;
  logic            timer_clr;
  logic            shift_en, par_smp, stop_smp;

  assign half_tc = (timer == HALF_TC);
  assign bit_tc  = (timer == BIT_TC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INICIAL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    shift_en  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      INICIAL: begin
        if (!sync) begin
          state_nxt = START;
          timer_clr = 1'b1;
        end
      end
      START: begin
        if (half_tc) begin
          timer_clr = 1'b1;
          state_nxt = sync ? INICIAL : DADOS;
        end
      end
      DADOS: begin
        if (bit_tc) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd6) state_nxt = PARIDADE;
        end
      end
      PARIDADE: begin
        if (bit_tc) begin
          par_smp   = 1'b1;
          state_nxt = PARADA;
        end
      end
      PARADA: begin
        if (bit_tc) begin
          stop_smp  = 1'b1;
          state_nxt = FINAL;
        end
      end
      // serr_q already holds this frame's stop result while in FINAL
      FINAL:   state_nxt = serr_q ? ESPERA : INICIAL;
      ESPERA:  if (sync) state_nxt = INICIAL;
      default: state_nxt = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1  <= 1'b1;
      sync     <= 1'b1;
      timer    <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      par_bit  <= 1'b0;
      data_q   <= 7'd0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      sync_q1 <= bus.dado_serial;
      sync    <= sync_q1;

      if (timer_clr || bit_tc) timer <= '0;
      else                     timer <= timer + 1'b1;

      if (state == START)  bit_cnt <= 3'd0;
      else if (shift_en)   bit_cnt <= bit_cnt + 3'd1;

      // shifting in from the top leaves the first bit received at position 0
      if (shift_en) shift   <= {sync, shift[6:1]};
      if (par_smp)  par_bit <= sync;

      // registered on the stop-sample edge so word, flags and pronto all
      // appear together during the FINAL cycle
      pronto_q <= stop_smp;
      if (stop_smp) begin
        data_q <= shift;
        perr_q <= ^{shift, par_bit};
        serr_q <= ~sync;
      end
    end
  end

  assign bus.dado_recebido = data_q;
  assign bus.pronto        = pronto_q;
  assign bus.erro_paridade = perr_q;
  assign bus.erro_parada   = serr_q;
  assign bus.db_estado     = state;

endmodule

// File: tb/tb_rx_serial_7e1.sv
module tb_rx_serial_7e1;
  localparam int CPB = 434;

  typedef struct packed {
    logic [6:0] data;
    logic       pe;
    logic       se;
  } rx_t;

  typedef struct {
    string      name;
    logic [6:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic [6:0] exp_data;
    logic       exp_pe;
    logic       exp_se;
  } vec_t;

  logic clock;
  logic reset;
  rx_serial_7e1_if bus();

  rx_serial_7e1 #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  viol_stable = 0;
  int  viol_width = 0;
  rx_t rxq[$];
  rx_t prev_out;
  logic prev_pronto;

  always @(posedge clock) cyc++;

  // Collects every pronto pulse and watches that the outputs never move
  // outside of one, and that pronto never lasts more than one cycle.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      if (bus.pronto) begin
        rxq.push_back('{bus.dado_recebido, bus.erro_paridade, bus.erro_parada});
        if (prev_pronto) viol_width++;
      end else if ({bus.dado_recebido, bus.erro_paridade, bus.erro_parada} != prev_out) begin
        viol_stable++;
      end
    end
    prev_out    = '{bus.dado_recebido, bus.erro_paridade, bus.erro_parada};
    prev_pronto = bus.pronto;
  end

  initial begin
    repeat (100000) @(posedge clock);
    $display("FAIL watchdog: cycle budget exhausted, got %0d cycles required < 100000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives start, 7 data bits LSB first, parity, stop; leaves the stop level on the line.
  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop);
    bus.dado_serial = 1'b0;
    hold(CPB);
    for (int k = 0; k < 7; k++) begin
      bus.dado_serial = d[k];
      hold(CPB);
    end
    bus.dado_serial = par;
    hold(CPB);
    bus.dado_serial = stop;
    hold(CPB);
  endtask

  task automatic expect_frame(input string name, input logic [6:0] d, input logic pe, input logic se);
    rx_t r;
    int  n = 0;
    while (rxq.size() == 0 && n < 2 * CPB) begin
      @(negedge clock);
      n++;
    end
    check({name, "_pronto"}, 32'(rxq.size() > 0), 32'd1);
    if (rxq.size() > 0) begin
      r = rxq.pop_front();
      check({name, "_data"}, 32'(r.data), 32'(d));
      check({name, "_perr"}, 32'(r.pe), 32'(pe));
      check({name, "_serr"}, 32'(r.se), 32'(se));
    end
  endtask

  // Reference rules: parity error when the count of ones over data+parity is odd;
  // framing error when the stop bit is low.
  function automatic logic model_pe(input logic [6:0] d, input logic par);
    return ((($countones(d) + int'(par)) % 2) != 0);
  endfunction

  vec_t       tbl[5];
  logic [6:0] d;
  logic [6:0] last_data;
  logic       par, stop;
  int         t_fall, n;

  initial begin
    tbl[0] = '{"f41",      7'h41, 1'b0, 1'b1, 50, 7'h41, 1'b0, 1'b0};
    tbl[1] = '{"f41_par",  7'h41, 1'b1, 1'b1, 50, 7'h41, 1'b1, 1'b0};
    tbl[2] = '{"b2b_31",   7'h31, 1'b1, 1'b1, 50, 7'h31, 1'b0, 1'b0};
    tbl[3] = '{"b2b_32",   7'h32, 1'b1, 1'b1,  0, 7'h32, 1'b0, 1'b0};
    tbl[4] = '{"b2b_7f",   7'h7F, 1'b1, 1'b1,  0, 7'h7F, 1'b0, 1'b0};

    reset = 1'b0;
    bus.dado_serial = 1'b1;
    hold(5);
    check("rst_data",   32'(bus.dado_recebido), 32'd0);
    check("rst_pronto", 32'(bus.pronto),        32'd0);
    check("rst_perr",   32'(bus.erro_paridade), 32'd0);
    check("rst_serr",   32'(bus.erro_parada),   32'd0);
    check("rst_state",  32'(bus.db_estado),     32'd0);
    reset = 1'b1;
    hold(20);

    for (int i = 0; i < 5; i++) begin
      hold(tbl[i].gap);
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
      expect_frame(tbl[i].name, tbl[i].exp_data, tbl[i].exp_pe, tbl[i].exp_se);
    end
    hold(CPB);

    // Framing error followed by a long break.
    send_frame(7'h35, 1'b0, 1'b0);
    expect_frame("brk", 7'h35, 1'b0, 1'b1);
    check("brk_espera_early", 32'(bus.db_estado), 32'd6);
    hold(2000);
    check("brk_espera_late", 32'(bus.db_estado), 32'd6);
    bus.dado_serial = 1'b1;
    hold(4);
    check("brk_release_state", 32'(bus.db_estado), 32'd0);
    hold(2 * CPB);
    check("brk_no_second_pronto", 32'(rxq.size()), 32'd0);
    last_data = 7'h35;

    // Short low glitch on an idle line.
    bus.dado_serial = 1'b0;
    t_fall = cyc;
    hold(50);
    check("glitch_in_start", 32'(bus.db_estado), 32'd1);
    hold(50);
    bus.dado_serial = 1'b1;
    n = 0;
    while (bus.db_estado != 4'd0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("glitch_back_idle", 32'(bus.db_estado), 32'd0);
    check("glitch_by_t0_217", 32'((cyc - t_fall) <= 224), 32'd1);
    hold(CPB);
    check("glitch_no_pronto", 32'(rxq.size()), 32'd0);
    check("glitch_data_kept", 32'(bus.dado_recebido), 32'(last_data));
    check("glitch_serr_kept", 32'(bus.erro_parada), 32'd1);

    // Reset in the middle of data bit 3.
    d = 7'h35;
    bus.dado_serial = 1'b0;
    hold(CPB);
    for (int k = 0; k < 3; k++) begin
      bus.dado_serial = d[k];
      hold(CPB);
    end
    bus.dado_serial = d[3];
    hold(CPB / 2);
    reset = 1'b0;
    hold(3);
    check("midrst_data",   32'(bus.dado_recebido), 32'd0);
    check("midrst_pronto", 32'(bus.pronto),        32'd0);
    check("midrst_perr",   32'(bus.erro_paridade), 32'd0);
    check("midrst_serr",   32'(bus.erro_parada),   32'd0);
    check("midrst_state",  32'(bus.db_estado),     32'd0);
    bus.dado_serial = 1'b1;
    hold(2);
    reset = 1'b1;
    hold(3 * CPB);
    check("midrst_no_pronto", 32'(rxq.size()), 32'd0);
    send_frame(7'h0A, 1'b0, 1'b1);
    expect_frame("after_rst_0a", 7'h0A, 1'b0, 1'b0);

    // Randomized frames against the reference rules.
    for (int i = 0; i < 5; i++) begin
      d    = 7'($urandom_range(0, 127));
      par  = ($countones(d) % 2 != 0);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop = ($urandom_range(0, 3) != 0);
      hold($urandom_range(0, 200));
      send_frame(d, par, stop);
      expect_frame($sformatf("rnd%0d", i), d, model_pe(d, par), ~stop);
      if (!stop) begin
        hold($urandom_range(1, 100));
        bus.dado_serial = 1'b1;
        hold(4);
      end
    end

    hold(CPB);
    check("no_extra_pronto",  32'(rxq.size()),  32'd0);
    check("outputs_stable",   32'(viol_stable), 32'd0);
    check("pronto_one_cycle", 32'(viol_width),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_serial_7e1.md
RX_SERIAL_7E1 -- requirements
Module: rx_serial_7e1

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning clock cycles per bit (50 MHz / 115200 baud).
REQ-002 Port clock  input  1  system clock, 50 MHz, all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 Port dado_serial  input  1  asynchronous serial line, idle high, 7E1 frames.
REQ-005 Port dado_recebido  output  7  last received data word, LSB first on the line.
REQ-006 Port pronto  output  1  one-cycle pulse marking completion of a frame.
REQ-007 Port erro_paridade  output  1  even-parity mismatch flag for the last frame.
REQ-008 Port erro_parada  output  1  framing error flag (stop bit sampled low) for the last frame.
REQ-009 Port db_estado  output  4  current FSM state code, for debug.

Function
REQ-010 dado_serial SHALL pass through a two-flop synchronizer; all decisions use the synchronized value (sync).
REQ-011 FSM states and codes SHALL be: INICIAL=0, START=1, DADOS=2, PARIDADE=3, PARADA=4, FINAL=5, ESPERA=6; db_estado SHALL equal the current code.
REQ-012 INICIAL: on sync=0, go to START, clear the bit-timer, and call this cycle T0.
REQ-013 START: at T0+CLKS_PER_BIT/2 (integer division), sample sync; if 0, go to DADOS and restart the timer; if 1, return to INICIAL as a glitch, with no output change.
REQ-014 DADOS: sample data bit k (k=0..6) at T0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT into shift register position k; after bit 6, go to PARIDADE.
REQ-015 PARIDADE: sample at T0+CLKS_PER_BIT/2+8*CLKS_PER_BIT; parity is correct when XOR of the 7 data bits and the parity bit equals 0.
REQ-016 PARADA: sample at T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT; stop bit is valid if 1.
REQ-017 FINAL, one cycle after the stop sample: load dado_recebido, erro_paridade and erro_parada together; pronto=1 for exactly this cycle.
REQ-018 The FINAL update SHALL happen on both good and errored frames; the flags then hold until the next FINAL.
REQ-019 After FINAL, go to INICIAL if the stop bit was 1, else go to ESPERA.
REQ-020 ESPERA: stay until sync=1, then go to INICIAL; a line held low (break) SHALL NOT produce further frames.
REQ-021 Bit-timer width SHALL be ceil(log2(CLKS_PER_BIT)) bits; the timer counts 0..CLKS_PER_BIT-1 and wraps.
REQ-022 Back-to-back frames SHALL be accepted: a start edge arriving one bit after the stop bit midpoint, or later, is detected from INICIAL.
REQ-023 Outside FINAL, outputs SHALL be stable; no partial word is ever visible on dado_recebido.

Reset
REQ-024 While reset=0, state=INICIAL; dado_recebido=0, pronto=0, erro_paridade=0, erro_parada=0, db_estado=0; the timer, shift register and synchronizer flops are set to idle (synchronizer=1).
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pronto pulse; after release, the next falling edge starts a new frame.

Verification
REQ-026 Frame 0x41 (line: 0,1,0,0,0,0,0,1,0,1, 434 clk/bit) -> one pronto pulse; dado_recebido=0x41, erro_paridade=0, erro_parada=0.
REQ-027 Frame 0x41 with parity bit 1 -> pronto pulse; dado_recebido=0x41, erro_paridade=1, erro_parada=0.
REQ-028 Frame 0x35 with stop bit 0, line held low 2000 clk, then high -> one pronto with erro_parada=1; db_estado=6 until the line is high, then 0; no second pronto.
REQ-029 Low glitch of 100 clk on an idle line -> returns to INICIAL by cycle T0+217; no pronto; outputs unchanged.
REQ-030 Frames 0x31, 0x32, 0x7F sent back-to-back with a 1-bit stop -> three pronto pulses in order with the matching data and both flags 0.
REQ-031 reset=0 asserted at data bit 3 of a frame -> no pronto and all outputs 0; a subsequent 0x0A frame is received correctly.
